// File: rtl/debounce_pkg.sv
// Shared definitions for input-conditioning blocks: debounce FSM state
// encoding, default stability window and a counter-width helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    CHK_HI  = 2'd1,
    IDLE_HI = 2'd2,
    CHK_LO  = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_DEF = 50000;

  // Width able to hold 0 .. n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    int w;
    w = $clog2(n);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/button_debouncer_sync_2ff.sv
// Generic single-bit two-flop synchroniser with asynchronous active-low
// reset to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button debouncer: 2-FF synchroniser, four-state stability FSM,
// registered level with one-cycle rise/fall pulses. Define BTN_COUNT_EN to
// add the wrapping press counter (COUNT_W parameter and btn_count port).
module button_debouncer
  import debounce_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
`ifdef BTN_COUNT_EN
  , parameter int COUNT_W = 8
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall
`ifdef BTN_COUNT_EN
  , output logic [COUNT_W-1:0] btn_count
`endif
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] stab_cnt_q, stab_cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (btn_raw),
    .q_o   (sync_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE_LO;
      stab_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      stab_cnt_q <= stab_cnt_d;
    end
  end

  // Counter restarts from 0 whenever the check is entered or abandoned.
  always_comb begin
    state_d    = state_q;
    stab_cnt_d = '0;
    case (state_q)
      IDLE_LO: begin
        if (sync_q) state_d = CHK_HI;
      end
      CHK_HI: begin
        if (!sync_q)                    state_d = IDLE_LO;
        else if (stab_cnt_q == CNT_MAX) state_d = IDLE_HI;
        else                            stab_cnt_d = stab_cnt_q + CNT_W'(1);
      end
      IDLE_HI: begin
        if (!sync_q) state_d = CHK_LO;
      end
      CHK_LO: begin
        if (sync_q)                     state_d = IDLE_HI;
        else if (stab_cnt_q == CNT_MAX) state_d = IDLE_LO;
        else                            stab_cnt_d = stab_cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE_LO;
    endcase
  end

  // Level follows the accepted state; pulses mark the cycle the level flips.
  always_comb begin
    level_d = (state_q == IDLE_HI) || (state_q == CHK_LO);
    rise_d  = level_d & ~level_q;
    fall_d  = ~level_d & level_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign btn_level = level_q;
  assign btn_rise  = rise_q;
  assign btn_fall  = fall_q;

`ifdef BTN_COUNT_EN
  logic [COUNT_W-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      count_q <= '0;
    else if (rise_d) count_q <= count_q + COUNT_W'(1);
  end

  assign btn_count = count_q;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4: reset, clean
// press/release, bounce rejection, reset mid-check and (BTN_COUNT_EN) counting.
module tb_button_debouncer;

  localparam int DEB = 4;
  localparam int LAT = DEB + 3;

  logic clk;
  logic rst_n;
  logic btn_raw;
  logic btn_level;
  logic btn_rise;
  logic btn_fall;
`ifdef BTN_COUNT_EN
  logic [7:0] btn_count;
`endif

  int errors;
  int checks;

  int   cyc;
  int   n_rise;
  int   n_fall;
  int   n_both;
  int   chg_at;
  int   rise_at;
  int   fall_at;
  logic lvl_start;

  button_debouncer #(
    .DEBOUNCE_CYCLES (DEB)
`ifdef BTN_COUNT_EN
    , .COUNT_W       (8)
`endif
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
`ifdef BTN_COUNT_EN
    , .btn_count (btn_count)
`endif
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic clear_stats();
    cyc       = 0;
    n_rise    = 0;
    n_fall    = 0;
    n_both    = 0;
    chg_at    = -1;
    rise_at   = -1;
    fall_at   = -1;
    lvl_start = btn_level;
  endtask

  // Called at a negedge: drive raw, run one posedge, sample at next negedge.
  task automatic step(input logic raw_v);
    btn_raw = raw_v;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (btn_rise) begin
      n_rise++;
      if (rise_at < 0) rise_at = cyc;
    end
    if (btn_fall) begin
      n_fall++;
      if (fall_at < 0) fall_at = cyc;
    end
    if (btn_rise && btn_fall) n_both++;
    if (chg_at < 0 && btn_level !== lvl_start) chg_at = cyc;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (btn_level !== 1'b0) begin errors++; $display("FAIL reset_level got=%b exp=0", btn_level); end
    checks++;
    if (btn_rise !== 1'b0) begin errors++; $display("FAIL reset_rise got=%b exp=0", btn_rise); end
    checks++;
    if (btn_fall !== 1'b0) begin errors++; $display("FAIL reset_fall got=%b exp=0", btn_fall); end
`ifdef BTN_COUNT_EN
    checks++;
    if (btn_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", btn_count); end
`endif
    rst_n = 1'b1;
    clear_stats();
    repeat (12) step(1'b1);
    checks++;
    if (chg_at - 1 != LAT) begin errors++; $display("FAIL reset_release_latency got=%0d exp=%0d", chg_at - 1, LAT); end
    checks++;
    if (n_rise != 1 || rise_at != chg_at) begin
      errors++; $display("FAIL reset_release_rise count=%0d at=%0d exp count=1 at=%0d", n_rise, rise_at, chg_at);
    end
    checks++;
    if (n_fall != 0) begin errors++; $display("FAIL reset_release_fall got=%0d exp=0", n_fall); end
  endtask

  task automatic test_release();
    clear_stats();
    repeat (12) step(1'b0);
    checks++;
    if (chg_at - 1 != LAT) begin errors++; $display("FAIL release_latency got=%0d exp=%0d", chg_at - 1, LAT); end
    checks++;
    if (btn_level !== 1'b0) begin errors++; $display("FAIL release_level got=%b exp=0", btn_level); end
    checks++;
    if (n_fall != 1 || fall_at != chg_at) begin
      errors++; $display("FAIL release_fall count=%0d at=%0d exp count=1 at=%0d", n_fall, fall_at, chg_at);
    end
    checks++;
    if (n_rise != 0) begin errors++; $display("FAIL release_rise got=%0d exp=0", n_rise); end
  endtask

  task automatic test_clean_press();
    clear_stats();
    repeat (20) step(1'b1);
    checks++;
    if (chg_at - 1 != LAT) begin errors++; $display("FAIL press_latency got=%0d exp=%0d", chg_at - 1, LAT); end
    checks++;
    if (btn_level !== 1'b1) begin errors++; $display("FAIL press_level got=%b exp=1", btn_level); end
    checks++;
    if (n_rise != 1 || rise_at != chg_at) begin
      errors++; $display("FAIL press_rise count=%0d at=%0d exp count=1 at=%0d", n_rise, rise_at, chg_at);
    end
    checks++;
    if (n_fall != 0 || n_both != 0) begin errors++; $display("FAIL press_fall fall=%0d both=%0d exp=0", n_fall, n_both); end
  endtask

  task automatic test_bounce();
    clear_stats();
    for (int i = 0; i < 16; i++) step(((i / 2) % 2) == 0);
    repeat (12) step(1'b0);
    checks++;
    if (btn_level !== 1'b0 || chg_at != -1) begin
      errors++; $display("FAIL bounce_level got=%b changed_at=%0d exp=0 never", btn_level, chg_at);
    end
    checks++;
    if (n_rise != 0 || n_fall != 0) begin errors++; $display("FAIL bounce_pulses rise=%0d fall=%0d exp=0", n_rise, n_fall); end
  endtask

  task automatic test_reset_mid_check();
    clear_stats();
    repeat (3) step(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 1'b0 || btn_rise !== 1'b0 || btn_fall !== 1'b0) begin
      errors++; $display("FAIL midcheck_outputs got=%b%b%b exp=000", btn_level, btn_rise, btn_fall);
    end
    @(negedge clk);
    btn_raw = 1'b0;
    rst_n   = 1'b1;
    clear_stats();
    repeat (12) step(1'b0);
    checks++;
    if (n_rise != 0 || n_fall != 0 || chg_at != -1) begin
      errors++; $display("FAIL midcheck_stray rise=%0d fall=%0d chg=%0d exp=0 0 -1", n_rise, n_fall, chg_at);
    end
    // Asynchronous clear while the accepted level is high.
    repeat (12) step(1'b1);
    rst_n = 1'b0;
    #1;
    checks++;
    if (btn_level !== 1'b0) begin errors++; $display("FAIL async_clear_high got=%b exp=0", btn_level); end
    @(negedge clk);
    btn_raw = 1'b0;
    rst_n   = 1'b1;
    clear_stats();
    repeat (10) step(1'b0);
    checks++;
    if (n_rise != 0 || n_fall != 0) begin errors++; $display("FAIL async_clear_stray rise=%0d fall=%0d exp=0", n_rise, n_fall); end
  endtask

`ifdef BTN_COUNT_EN
  task automatic test_count();
    logic [7:0] exp_cnt;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 257; i++) begin
      clear_stats();
      repeat (9) step(1'b1);
      exp_cnt = exp_cnt + 8'd1;
      checks++;
      if (n_rise != 1 || btn_count !== exp_cnt) begin
        errors++; $display("FAIL count_press%0d got=%0d rises=%0d exp=%0d", i, btn_count, n_rise, exp_cnt);
      end
      repeat (9) step(1'b0);
    end
    checks++;
    if (btn_count !== 8'd1) begin errors++; $display("FAIL count_wrap_final got=%0d exp=1", btn_count); end
  endtask
`endif

  // ---------------- sequence and report ----------------
  initial begin
    errors  = 0;
    checks  = 0;
    rst_n   = 1'b0;
    btn_raw = 1'b0;
    @(negedge clk);
    test_reset();
    test_release();
    test_clean_press();
    test_release();
    test_bounce();
    test_reset_mid_check();
`ifdef BTN_COUNT_EN
    test_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
